// File: rtl/and_gate_pkg.sv
// Shared defaults and counter-control encoding for the and_gate cell.
package and_gate_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic {
    CNT_HOLD = 1'b0,
    CNT_INC  = 1'b1
  } cnt_op_e;

endpackage : and_gate_pkg

// File: rtl/and_gate_if.sv
// Operand/result bundle for and_gate; master drives operands, slave drives results.
interface and_gate_if
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             y_all;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output a, b,
    input  y, y_all, y_q, hit_cnt
  );

  modport slave (
    input  a, b,
    output y, y_all, y_q, hit_cnt
  );

endinterface : and_gate_if

// File: rtl/and_gate_stat.sv
// Observability side of and_gate: registered copy of y and a saturating all-ones hit counter.
module and_gate_stat
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_y_all,
  output logic [WIDTH-1:0] o_y_q,
  output logic [CNT_W-1:0] o_hit_cnt
);

  logic [WIDTH-1:0] r_y_q;
  logic [CNT_W-1:0] r_hit_cnt;
  cnt_op_e          w_op;

  // Saturate at all-ones rather than wrapping back to zero.
  assign w_op = (i_y_all === 1'b1 && r_hit_cnt != {CNT_W{1'b1}}) ? CNT_INC : CNT_HOLD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q     <= '0;
      r_hit_cnt <= '0;
    end else begin
      r_y_q <= i_y;
      if (w_op == CNT_INC) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
    end
  end

  assign o_y_q     = r_y_q;
  assign o_hit_cnt = r_hit_cnt;

endmodule : and_gate_stat

// File: rtl/and_gate.sv
// Bitwise AND cell: zero-latency combinational result plus registered status outputs.
module and_gate
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  and_gate_if.slave  io
);

  logic [WIDTH-1:0] w_y;
  logic             w_y_all;

  // Combinational path is independent of clk and rst_n.
  assign w_y      = io.a & io.b;
  assign w_y_all  = &w_y;
  assign io.y     = w_y;
  assign io.y_all = w_y_all;

  and_gate_stat #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_stat (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_y       (w_y),
    .i_y_all   (w_y_all),
    .o_y_q     (io.y_q),
    .o_hit_cnt (io.hit_cnt)
  );

endmodule : and_gate

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: stimulus queues expected values, a monitor compares them.
module tb_and_gate;

  logic clk;
  logic clk_en;
  logic rst_n;

  and_gate_if #(.WIDTH(1), .CNT_W(2)) bus1 ();
  and_gate_if #(.WIDTH(4), .CNT_W(8)) bus4 ();

  and_gate #(.WIDTH(1), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .io(bus1.slave));
  and_gate #(.WIDTH(4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .io(bus4.slave));

  typedef enum int {K_Y1, K_YALL1, K_YQ1, K_CNT1, K_Y4, K_YALL4, K_YQ4} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] exp;
    string      name;
  } item_t;

  item_t q[$];
  event  ev_chk;
  int    n_checks = 0;
  int    n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, required finish before 100000 ns");
    $fatal(1, "watchdog");
  end

  // Monitor: every trigger drains the queue against the DUT's current outputs.
  always @(ev_chk) begin
    while (q.size() > 0) begin
      item_t      it;
      logic [7:0] act;
      it  = q.pop_front();
      act = 8'h00;
      case (it.kind)
        K_Y1:    act = {7'b0, bus1.y};
        K_YALL1: act = {7'b0, bus1.y_all};
        K_YQ1:   act = {7'b0, bus1.y_q};
        K_CNT1:  act = {6'b0, bus1.hit_cnt};
        K_Y4:    act = {4'b0, bus4.y};
        K_YALL4: act = {7'b0, bus4.y_all};
        K_YQ4:   act = {4'b0, bus4.y_q};
        default: act = 8'hxx;
      endcase
      n_checks++;
      if (act !== it.exp) begin
        n_errors++;
        $display("FAIL %s: got %h, expected %h at %0t", it.name, act, it.exp, $time);
      end
    end
  end

  task automatic expect_v(input kind_e k, input logic [7:0] v, input string nm);
    item_t it;
    it.kind = k;
    it.exp  = v;
    it.name = nm;
    q.push_back(it);
  endtask

  task automatic fire();
    -> ev_chk;
    #1;
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_ab [4];
  logic       tt_y  [4];

  initial begin
    tt_ab = '{2'b00, 2'b01, 2'b10, 2'b11};
    tt_y  = '{1'b0, 1'b0, 1'b0, 1'b1};
    clk_en = 1'b0;
    rst_n  = 1'b1;
    bus1.a = 1'b0; bus1.b = 1'b0;
    bus4.a = 4'h0; bus4.b = 4'h0;

    // Unclocked truth table.
    for (int i = 0; i < 4; i++) begin
      bus1.a = tt_ab[i][1];
      bus1.b = tt_ab[i][0];
      #1;
      expect_v(K_Y1,    {7'b0, tt_y[i]}, $sformatf("tt_y_%0d",    i));
      expect_v(K_YALL1, {7'b0, tt_y[i]}, $sformatf("tt_yall_%0d", i));
      fire();
      #8;
    end

    // Multi-bit combinational vectors.
    bus4.a = 4'b1100; bus4.b = 4'b1010;
    #1;
    expect_v(K_Y4,    8'h08, "w4_y_mixed");
    expect_v(K_YALL4, 8'h00, "w4_yall_mixed");
    fire();
    bus4.a = 4'hF; bus4.b = 4'hF;
    #1;
    expect_v(K_Y4,    8'h0F, "w4_y_ones");
    expect_v(K_YALL4, 8'h01, "w4_yall_ones");
    fire();

    // Reset transparency.
    rst_n  = 1'b0;
    bus1.a = 1'b1; bus1.b = 1'b1;
    #1;
    expect_v(K_Y1,   8'h01, "rst_y");
    expect_v(K_YQ1,  8'h00, "rst_yq");
    expect_v(K_CNT1, 8'h00, "rst_cnt");
    fire();

    // Registered latency.
    bus1.a = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    after_pos();
    expect_v(K_YQ1,  8'h00, "lat_yq_idle");
    expect_v(K_CNT1, 8'h00, "lat_cnt_idle");
    fire();
    @(negedge clk);
    bus1.a = 1'b1; bus1.b = 1'b1;
    #1;
    expect_v(K_YQ1, 8'h00, "lat_yq_before_edge");
    fire();
    after_pos();
    expect_v(K_YQ1,  8'h01, "lat_yq_after_edge");
    expect_v(K_CNT1, 8'h01, "lat_cnt_1");
    expect_v(K_YQ4,  8'h0F, "w4_yq");
    fire();
    @(negedge clk);
    bus1.b = 1'b0;
    #1;
    expect_v(K_Y1,  8'h00, "lat_y_drop");
    expect_v(K_YQ1, 8'h01, "lat_yq_hold");
    fire();
    after_pos();
    expect_v(K_YQ1,  8'h00, "lat_yq_drop");
    expect_v(K_CNT1, 8'h01, "lat_cnt_hold");
    fire();

    // Reach hit_cnt=2, then async reset between edges.
    @(negedge clk);
    bus1.b = 1'b1;
    after_pos();
    expect_v(K_CNT1, 8'h02, "ar_cnt_2");
    fire();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expect_v(K_CNT1, 8'h00, "ar_cnt_clr");
    expect_v(K_YQ1,  8'h00, "ar_yq_clr");
    expect_v(K_Y1,   8'h01, "ar_y_kept");
    fire();
    rst_n = 1'b1;

    // Saturation with a=b=1 held.
    for (int i = 0; i < 5; i++) begin
      after_pos();
      expect_v(K_CNT1, (i < 3) ? 8'(i + 1) : 8'h03, $sformatf("sat_cnt_%0d", i));
      expect_v(K_YQ1,  8'h01, $sformatf("sat_yq_%0d", i));
      fire();
    end
    @(negedge clk);
    bus1.a = 1'b0;
    for (int i = 0; i < 2; i++) begin
      after_pos();
      expect_v(K_CNT1, 8'h03, $sformatf("sat_hold_%0d", i));
      fire();
    end

    #20;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_and_gate
